// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init-sequencer state codes,
// default mode register value and the registered command-bus payload.
package sdram_pkg;

  localparam int unsigned BA_W   = 2;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned ST_W   = 3;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LMR       = 4'b0000;

  // CL3, burst length 4, sequential
  localparam logic [ADDR_W-1:0] MODE_REG_DEFAULT = 13'h032;
  localparam logic [ADDR_W-1:0] ADDR_A10         = 13'h400;

  // Init sequencer state encoding
  localparam logic [ST_W-1:0] ST_WAIT_PU  = 3'd0;
  localparam logic [ST_W-1:0] ST_PRECH    = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_RP  = 3'd2;
  localparam logic [ST_W-1:0] ST_REF      = 3'd3;
  localparam logic [ST_W-1:0] ST_WAIT_RFC = 3'd4;
  localparam logic [ST_W-1:0] ST_LMR      = 3'd5;
  localparam logic [ST_W-1:0] ST_WAIT_MRD = 3'd6;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd7;

  typedef struct packed {
    logic              cke;
    logic [3:0]        cmd;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;
    logic              init_done;
  } sdram_init_bus_t;

  localparam sdram_init_bus_t BUS_RESET = {1'b0, CMD_INHIBIT, 2'b00, 13'h0000, 1'b0};

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_init_seq_if.sv
// SDRAM command bus plus init_done as driven by the power-up init sequencer.
interface sdram_init_seq_if;
  import sdram_pkg::*;

  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic              init_done;

  modport master (
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
           sdram_ba, sdram_addr, init_done
  );

  modport slave (
    input sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
          sdram_ba, sdram_addr, init_done
  );

endinterface

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter; zero is registered and high once the loaded count has expired.
module sdram_wait_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else if (load) begin
      cnt  <= value;
      zero <= (value == '0);
    end else if (!zero) begin
      cnt  <= cnt - W'(1);
      zero <= (cnt == W'(1));
    end
  end

endmodule

// File: rtl/sdram_init_seq.sv
// JEDEC SDRAM power-up sequencer: power-up wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE REGISTER. Define SDRAM_INIT_REINIT_EN to add reinit_req (restart from PRECHARGE).
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int unsigned       T_POWERUP_CYC = 20000,
  parameter int unsigned       T_RP          = 2,
  parameter int unsigned       T_RFC         = 7,
  parameter int unsigned       T_MRD         = 2,
  parameter int unsigned       REFRESH_COUNT = 8,
  parameter logic [ADDR_W-1:0] MODE_REG      = MODE_REG_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SDRAM_INIT_REINIT_EN
  input  logic reinit_req,
`endif
  sdram_init_seq_if.master sdram
);

  localparam int unsigned PU_W    = $clog2(T_POWERUP_CYC + 1);
  localparam int unsigned TMR_MAX = max3(T_RP, T_RFC, T_MRD);
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  if (T_POWERUP_CYC == 0 || T_RP == 0 || T_RFC == 0 || T_MRD == 0) begin : g_bad_timing
    $error("sdram_init_seq: timing parameters must be at least 1");
  end
  if (REFRESH_COUNT == 0 || REFRESH_COUNT > 15) begin : g_bad_refresh
    $error("sdram_init_seq: REFRESH_COUNT must be in 1..15");
  end

  logic [ST_W-1:0]  state, state_next;
  logic [PU_W-1:0]  pu_cnt;
  logic [3:0]       ref_cnt, ref_cnt_next;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_zero;
  sdram_init_bus_t  bus_next, bus_q;

  // Shared wait timer for tRP / tRFC / tMRD, loaded as each command issues
  sdram_wait_timer #(.W(TMR_W)) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT_PU;
    else        state <= state_next;
  end

  // Next state, then the registered bus image of the state being entered
  always_comb begin
    state_next   = state;
    ref_cnt_next = ref_cnt;
    tmr_load     = 1'b0;
    tmr_value    = '0;
    bus_next     = {1'b1, CMD_NOP, 2'b00, 13'h0000, 1'b0};

    case (state)
      ST_WAIT_PU:  if (pu_cnt == '0) state_next = ST_PRECH;
      ST_PRECH:    state_next = tmr_zero ? ST_REF : ST_WAIT_RP;
      ST_WAIT_RP:  if (tmr_zero) state_next = ST_REF;
      ST_REF, ST_WAIT_RFC: begin
        if (tmr_zero)            state_next = (ref_cnt < 4'(REFRESH_COUNT)) ? ST_REF : ST_LMR;
        else if (state == ST_REF) state_next = ST_WAIT_RFC;
      end
      ST_LMR:      state_next = tmr_zero ? ST_DONE : ST_WAIT_MRD;
      ST_WAIT_MRD: if (tmr_zero) state_next = ST_DONE;
      ST_DONE: begin
`ifdef SDRAM_INIT_REINIT_EN
        if (reinit_req) state_next = ST_PRECH;
`endif
      end
      default:     state_next = ST_WAIT_PU;
    endcase

    case (state_next)
      ST_PRECH: begin
        bus_next.cmd  = CMD_PRECHARGE;
        bus_next.addr = ADDR_A10;
        tmr_load      = 1'b1;
        tmr_value     = TMR_W'(T_RP - 1);
        ref_cnt_next  = '0;
      end
      ST_REF: begin
        bus_next.cmd  = CMD_REFRESH;
        tmr_load      = 1'b1;
        tmr_value     = TMR_W'(T_RFC - 1);
        ref_cnt_next  = ref_cnt + 4'd1;
      end
      ST_LMR: begin
        bus_next.cmd  = CMD_LMR;
        bus_next.addr = MODE_REG;
        tmr_load      = 1'b1;
        tmr_value     = TMR_W'(T_MRD - 1);
      end
      ST_DONE:  bus_next.init_done = 1'b1;
      default:  ;
    endcase
  end

  // Power-up wait counts down from reset; not reloaded by a reinit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  pu_cnt <= PU_W'(T_POWERUP_CYC);
    else if (state == ST_WAIT_PU && pu_cnt != '0) pu_cnt <= pu_cnt - PU_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      bus_q   <= BUS_RESET;
    end else begin
      ref_cnt <= ref_cnt_next;
      bus_q   <= bus_next;
    end
  end

  assign sdram.sdram_cke   = bus_q.cke;
  assign sdram.sdram_cs_n  = bus_q.cmd[3];
  assign sdram.sdram_ras_n = bus_q.cmd[2];
  assign sdram.sdram_cas_n = bus_q.cmd[1];
  assign sdram.sdram_we_n  = bus_q.cmd[0];
  assign sdram.sdram_ba    = bus_q.ba;
  assign sdram.sdram_addr  = bus_q.addr;
  assign sdram.init_done   = bus_q.init_done;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: two parameterisations checked every cycle against a schedule
// model, with randomized asynchronous resets; reinit tests when SDRAM_INIT_REINIT_EN is set.
`timescale 1ns/1ps
module tb_sdram_init_seq;

  localparam int PU = 10;
  localparam logic [3:0] C_NOP = 4'b0111, C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;
  localparam logic [20:0] RST_W = {1'b0, 4'b1111, 2'b00, 13'h0000, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reinit = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   tick = 0;

  int         last_cyc[2];
  logic [3:0] last_cmd[2];
  int         nref[2];
  logic       done_q[2];

  always #5 clk = ~clk;

  sdram_init_seq_if ia ();
  sdram_init_seq_if ib ();

  sdram_init_seq #(.T_POWERUP_CYC(PU)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SDRAM_INIT_REINIT_EN
    .reinit_req (reinit),
`endif
    .sdram      (ia.master)
  );

  sdram_init_seq #(.T_POWERUP_CYC(PU), .T_RFC(3), .REFRESH_COUNT(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SDRAM_INIT_REINIT_EN
    .reinit_req (reinit),
`endif
    .sdram      (ib.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s tick=%0d got=%h exp=%h", tag, tick, got, exp);
    end
  endtask

  // Expected bus in cycle k after reset release, straight from the command schedule
  function automatic logic [20:0] model(input int k, input int pu, input int rp,
                                        input int rfc, input int mrd, input int rc);
    int t_ref, t_lmr;
    logic [3:0] c;
    logic [12:0] a;
    logic dn;
    t_ref = pu + rp;
    t_lmr = t_ref + rc * rfc;
    c = C_NOP;
    a = 13'h0000;
    if (k == pu) begin
      c = C_PRE;
      a = 13'h0400;
    end else if (k >= t_ref && k < t_lmr && ((k - t_ref) % rfc) == 0) begin
      c = C_REF;
    end else if (k == t_lmr) begin
      c = C_LMR;
      a = 13'h0032;
    end
    dn = (k >= t_lmr + mrd);
    return {1'b1, c, 2'b00, a, dn};
  endfunction

  function automatic logic [20:0] word_a();
    return {ia.sdram_cke, ia.sdram_cs_n, ia.sdram_ras_n, ia.sdram_cas_n, ia.sdram_we_n,
            ia.sdram_ba, ia.sdram_addr, ia.init_done};
  endfunction

  function automatic logic [20:0] word_b();
    return {ib.sdram_cke, ib.sdram_cs_n, ib.sdram_ras_n, ib.sdram_cas_n, ib.sdram_we_n,
            ib.sdram_ba, ib.sdram_addr, ib.init_done};
  endfunction

  task automatic mon_reset();
    for (int d = 0; d < 2; d++) begin
      last_cyc[d] = -1;
      last_cmd[d] = C_NOP;
      nref[d]     = 0;
      done_q[d]   = 1'b0;
    end
  endtask

  // Protocol monitor: command spacing and refresh count at init_done rise
  task automatic mon(input int d, input logic [20:0] w, input int rp, input int rfc,
                     input int mrd, input int rc);
    logic [3:0] c;
    int req;
    c = w[19:16];
    if (c == C_PRE || c == C_REF || c == C_LMR) begin
      if (last_cyc[d] >= 0) begin
        req = (last_cmd[d] == C_PRE) ? rp : (last_cmd[d] == C_REF) ? rfc : mrd;
        check($sformatf("gap%0d", d), 32'(tick - last_cyc[d] >= req), 32'd1);
      end
      if (c == C_REF) nref[d]++;
      if (c == C_PRE) nref[d] = 0;
      last_cyc[d] = tick;
      last_cmd[d] = c;
    end
    if (w[0] && !done_q[d]) check($sformatf("nref%0d", d), 32'(nref[d]), 32'(rc));
    done_q[d] = w[0];
  endtask

  task automatic sample(input int k_eff);
    logic [20:0] wa, wb;
    wa = word_a();
    wb = word_b();
    check("bus_a", 32'(wa), 32'(model(k_eff, PU, 2, 7, 2, 8)));
    check("bus_b", 32'(wb), 32'(model(k_eff, PU, 2, 3, 2, 2)));
    mon(0, wa, 2, 7, 2, 8);
    mon(1, wb, 2, 3, 2, 2);
    tick++;
  endtask

  // Called at a negedge; asserts reset mid-cycle and releases it on a later negedge
  task automatic do_reset(input int len);
    #2 rst_n = 1'b0;
    #1;
    check("async_a", 32'(word_a()), 32'(RST_W));
    check("async_b", 32'(word_b()), 32'(RST_W));
    mon_reset();
    repeat (len) begin
      @(negedge clk);
      check("rst_a", 32'(word_a()), 32'(RST_W));
      check("rst_b", 32'(word_b()), 32'(RST_W));
      tick++;
    end
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(k);
    end
  endtask

  initial begin
    mon_reset();
    repeat (5) begin
      @(negedge clk);
      check("rst_a", 32'(word_a()), 32'(RST_W));
      check("rst_b", 32'(word_b()), 32'(RST_W));
      tick++;
    end
    rst_n = 1'b1;
    run(90);

    do_reset(3);
    run(41);
    do_reset(2);
    run(90);

    repeat (12) begin
      do_reset(int'($urandom_range(1, 6)));
      run(int'($urandom_range(1, 100)));
    end

`ifdef SDRAM_INIT_REINIT_EN
    do_reset(2);
    for (int k = 0; k < 175; k++) begin
      @(posedge clk);
      #1 reinit = (k == 12 || k == 100);
      @(negedge clk);
      sample((k > 100) ? (k - 101 + PU) : k);
    end
    reinit = 1'b0;
`endif

    do_reset(4);
    run(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
